// File: rtl/uart_word_serializer.sv
// Streams one wide result word to uart_tx as bytes over the start/done handshake.
// state | meaning: IDLE wait load | START start pulse | WAIT byte in uart_tx | GAP pacing | DONE end pulse
module uart_word_serializer #(
  parameter int WORD_W    = 1028,
  parameter int GAP_CYC   = 0,
  parameter bit MSB_FIRST = 1'b0,
  localparam int NBYTES   = (WORD_W + 7) / 8,
  localparam int IDX_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [WORD_W-1:0] i_word,
  output logic              o_ready,
  output logic              o_busy,
  output logic              o_tx_start,
  output logic [7:0]        o_tx_byte,
  input  logic              i_tx_done,
  output logic              o_done,
  output logic [IDX_W-1:0]  o_byte_idx
);

  localparam int SR_W = NBYTES * 8;
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_GAP, S_DONE} state_t;

  state_t          state;
  logic [SR_W-1:0] shreg;
  logic [SR_W-1:0] shreg_nxt;
  logic [GAP_W-1:0] gap_cnt;

  // The byte to send is always at the leading end of the shift register.
  function automatic logic [7:0] head_byte(input logic [SR_W-1:0] v);
    return MSB_FIRST ? v[SR_W-1 -: 8] : v[7:0];
  endfunction

  always_comb begin
    shreg_nxt = MSB_FIRST ? (shreg << 8) : (shreg >> 8);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= S_IDLE;
      shreg      <= '0;
      gap_cnt    <= '0;
      o_ready    <= 1'b1;
      o_busy     <= 1'b0;
      o_tx_start <= 1'b0;
      o_done     <= 1'b0;
      o_tx_byte  <= 8'h00;
      o_byte_idx <= '0;
    end else begin
      o_tx_start <= 1'b0;
      o_done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_load) begin
            shreg      <= SR_W'(i_word);
            o_tx_byte  <= head_byte(SR_W'(i_word));
            o_byte_idx <= '0;
            o_ready    <= 1'b0;
            o_busy     <= 1'b1;
            o_tx_start <= 1'b1;
            state      <= S_START;
          end
        end
        S_START: state <= S_WAIT;
        S_WAIT: begin
          if (i_tx_done) begin
            if (o_byte_idx == LAST_IDX) begin
              o_done <= 1'b1;
              o_busy <= 1'b0;
              state  <= S_DONE;
            end else begin
              // o_tx_byte may change now: uart_tx has finished with the old byte.
              shreg      <= shreg_nxt;
              o_tx_byte  <= head_byte(shreg_nxt);
              o_byte_idx <= o_byte_idx + 1'b1;
              if (GAP_CYC > 0) begin
                gap_cnt <= GAP_W'(GAP_CYC - 1);
                state   <= S_GAP;
              end else begin
                o_tx_start <= 1'b1;
                state      <= S_START;
              end
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == '0) begin
            o_tx_start <= 1'b1;
            state      <= S_START;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        S_DONE: begin
          o_ready <= 1'b1;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_word_serializer.sv
// Bench for uart_word_serializer: three instances (default, GAP_CYC=3, MSB_FIRST=1)
// checked every cycle against a byte-order/timing model of the transfer.
module tb_uart_word_serializer;

  localparam int NB = 129;

  logic          clk;
  logic          rst      [3];
  logic          ld       [3];
  logic          tx_done  [3];
  logic [1027:0] word;
  logic          ready    [3];
  logic          busy     [3];
  logic          tx_start [3];
  logic [7:0]    tx_byte  [3];
  logic          done     [3];
  logic [7:0]    byte_idx [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    uart_word_serializer #(
      .WORD_W   (1028),
      .GAP_CYC  ((g == 1) ? 3 : 0),
      .MSB_FIRST(g == 2)
    ) u_dut (
      .i_clk     (clk),
      .i_rst     (rst[g]),
      .i_load    (ld[g]),
      .i_word    (word),
      .o_ready   (ready[g]),
      .o_busy    (busy[g]),
      .o_tx_start(tx_start[g]),
      .o_tx_byte (tx_byte[g]),
      .i_tx_done (tx_done[g]),
      .o_done    (done[g]),
      .o_byte_idx(byte_idx[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int exp_start [3];
  int exp_done [3];
  int ready_from [3];
  int nsent [3];
  int last_txdone [3];
  int nstarts [3];
  int ndone [3];
  int min_sp [3];
  int max_sp [3];
  int dsp [3];
  int cnt [3];
  bit active [3];
  bit waiting [3];
  bit inj [3];
  logic [7:0] first_b [3];
  logic [7:0] second_b [3];
  logic [7:0] last_b [3];
  logic [1031:0] lw [3];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Byte n of a transfer: LSB-first walks the padded word upward, MSB-first downward.
  function automatic logic [7:0] model_byte(input int g, input int n);
    logic [1031:0] v;
    v = lw[g];
    if (g == 2) return v[8*(NB-1-n) +: 8];
    return v[8*n +: 8];
  endfunction

  task automatic tick();
    for (int g = 0; g < 3; g++) begin
      tx_done[g] = 1'b0;
      if (cnt[g] > 0) begin
        cnt[g]--;
        if (cnt[g] == 0) tx_done[g] = 1'b1;
      end
      if (inj[g]) begin
        tx_done[g] = 1'b1;
        inj[g] = 1'b0;
      end
    end
    for (int g = 0; g < 3; g++) begin
      bit exp_st, exp_dn, exp_rdy;
      exp_st  = (cyc == exp_start[g]);
      exp_dn  = (cyc == exp_done[g]);
      exp_rdy = !active[g] && (cyc >= ready_from[g]);
      chk($sformatf("u%0d tx_start", g), tx_start[g], exp_st);
      chk($sformatf("u%0d done", g), done[g], exp_dn);
      chk($sformatf("u%0d ready", g), ready[g], exp_rdy);
      if (exp_st) begin
        chk($sformatf("u%0d start_byte", g), tx_byte[g], model_byte(g, nsent[g]));
        chk($sformatf("u%0d start_idx", g), byte_idx[g], nsent[g]);
        chk($sformatf("u%0d start_busy", g), busy[g], 1);
      end else if (waiting[g]) begin
        chk($sformatf("u%0d hold_byte", g), tx_byte[g], model_byte(g, nsent[g] - 1));
        chk($sformatf("u%0d hold_idx", g), byte_idx[g], nsent[g] - 1);
        chk($sformatf("u%0d hold_busy", g), busy[g], 1);
      end
      if (exp_dn) chk($sformatf("u%0d done_busy", g), busy[g], 0);

      if (tx_start[g] === 1'b1) begin
        nstarts[g]++;
        if (nstarts[g] == 1) first_b[g] = tx_byte[g];
        if (nstarts[g] == 2) second_b[g] = tx_byte[g];
        last_b[g] = tx_byte[g];
        if (nstarts[g] > 1 && last_txdone[g] >= 0) begin
          if (cyc - last_txdone[g] < min_sp[g]) min_sp[g] = cyc - last_txdone[g];
          if (cyc - last_txdone[g] > max_sp[g]) max_sp[g] = cyc - last_txdone[g];
        end
        cnt[g] = 10;
      end
      if (done[g] === 1'b1) begin
        ndone[g]++;
        dsp[g] = cyc - last_txdone[g];
      end

      if (rst[g]) begin
        active[g] = 1'b0;
        waiting[g] = 1'b0;
        exp_start[g] = -1;
        exp_done[g] = -1;
        ready_from[g] = cyc + 1;
      end else if (ld[g] && exp_rdy) begin
        lw[g] = 1032'(word);
        nsent[g] = 0;
        active[g] = 1'b1;
        exp_start[g] = cyc + 1;
        nstarts[g] = 0;
        ndone[g] = 0;
        min_sp[g] = 9999;
        max_sp[g] = 0;
        last_txdone[g] = -1;
      end else if (tx_done[g] && waiting[g]) begin
        waiting[g] = 1'b0;
        last_txdone[g] = cyc;
        if (nsent[g] == NB) begin
          exp_done[g] = cyc + 1;
          active[g] = 1'b0;
          ready_from[g] = cyc + 2;
        end else begin
          exp_start[g] = cyc + 1 + ((g == 1) ? 3 : 0);
        end
      end
      if (exp_st && !rst[g]) begin
        waiting[g] = 1'b1;
        nsent[g]++;
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic load(input int g);
    ld[g] = 1'b1;
    tick();
    ld[g] = 1'b0;
  endtask

  task automatic run_done(input int g, input int budget);
    int n;
    n = 0;
    while (ndone[g] == 0 && n < budget) begin
      tick();
      n++;
    end
    chk($sformatf("u%0d done_timeout", g), (ndone[g] != 0), 1);
    repeat (3) tick();
  endtask

  task automatic run_starts(input int g, input int k, input int budget);
    int n;
    n = 0;
    while (nstarts[g] < k && n < budget) begin
      tick();
      n++;
    end
    chk($sformatf("u%0d start_timeout", g), (nstarts[g] >= k), 1);
  endtask

  logic [1027:0] base_word;

  initial begin
    for (int g = 0; g < 3; g++) begin
      rst[g] = 1'b1;
      ld[g] = 1'b0;
      tx_done[g] = 1'b0;
      inj[g] = 1'b0;
      cnt[g] = 0;
      active[g] = 1'b0;
      waiting[g] = 1'b0;
      exp_start[g] = -1;
      exp_done[g] = -1;
      ready_from[g] = 0;
      nsent[g] = 0;
      nstarts[g] = 0;
      ndone[g] = 0;
      last_txdone[g] = -1;
      min_sp[g] = 9999;
      max_sp[g] = 0;
      dsp[g] = 0;
      lw[g] = '0;
    end
    base_word = '0;
    for (int k = 0; k < 128; k++) base_word[8*k +: 8] = 8'(k);
    base_word[1027:1024] = 4'hA;
    word = base_word;

    @(negedge clk);
    repeat (3) tick();
    for (int g = 0; g < 3; g++) rst[g] = 1'b0;
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("u%0d rst_ready", g), ready[g], 1);
      chk($sformatf("u%0d rst_busy", g), busy[g], 0);
      chk($sformatf("u%0d rst_start", g), tx_start[g], 0);
      chk($sformatf("u%0d rst_done", g), done[g], 0);
      chk($sformatf("u%0d rst_byte", g), tx_byte[g], 8'h00);
      chk($sformatf("u%0d rst_idx", g), byte_idx[g], 0);
    end

    // Default LSB-first transfer
    load(0);
    run_done(0, 2500);
    chk("t2 nstarts", nstarts[0], 129);
    chk("t2 ndone", ndone[0], 1);
    chk("t2 first", first_b[0], 8'h00);
    chk("t2 second", second_b[0], 8'h01);
    chk("t2 last", last_b[0], 8'h0A);
    chk("t2 min_spacing", min_sp[0], 1);
    chk("t2 max_spacing", max_sp[0], 1);
    chk("t2 done_spacing", dsp[0], 1);

    // Stray done in IDLE, then a second load and word change mid-transfer
    inj[0] = 1'b1;
    repeat (3) tick();
    load(0);
    run_starts(0, 6, 200);
    word = ~base_word;
    ld[0] = 1'b1;
    tick();
    ld[0] = 1'b0;
    run_done(0, 2500);
    word = base_word;
    chk("t3 nstarts", nstarts[0], 129);
    chk("t3 ndone", ndone[0], 1);
    chk("t3 last", last_b[0], 8'h0A);

    // Gap pacing
    load(1);
    run_done(1, 3000);
    chk("t4 nstarts", nstarts[1], 129);
    chk("t4 min_spacing", min_sp[1], 4);
    chk("t4 max_spacing", max_sp[1], 4);
    chk("t4 done_spacing", dsp[1], 1);
    chk("t4 last", last_b[1], 8'h0A);

    // Reset mid-transfer
    load(0);
    run_starts(0, 5, 200);
    tick();
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    repeat (20) tick();
    chk("t5 nstarts", nstarts[0], 5);
    chk("t5 ndone", ndone[0], 0);
    load(0);
    run_starts(0, 1, 10);
    chk("t5 first_after_rst", first_b[0], 8'h00);
    run_done(0, 2500);
    chk("t5 nstarts_after_rst", nstarts[0], 129);

    // MSB-first
    load(2);
    run_done(2, 2500);
    chk("t6 nstarts", nstarts[2], 129);
    chk("t6 first", first_b[2], 8'h0A);
    chk("t6 second", second_b[2], 8'h7F);
    chk("t6 last", last_b[2], 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
